id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage of the RV32 core. Sits directly upstream of the execute ALU. It registers decoded operands and control, and resolves register-file hazards with MEM and WB bypassing. It presents the ALU with final `a`, `b` and `alucontrol` under a valid/ready handshake, and supports stall and flush.

## Interface
- `XLEN`, 32, datapath width.
- `clk` in 1, rising-edge clock.
- `reset_n` in 1, asynchronous active-low reset.
- `in_valid` in 1, decode presents an instruction.
- `in_ready` out 1, stage can accept this cycle.
- `in_rs1_data`, `in_rs2_data`, `in_imm` in XLEN, register-file reads and immediate.
- `in_rs1`, `in_rs2`, `in_rd` in 5, register addresses.
- `in_alusrc` in 1, 1 selects `in_imm` for `b`.
- `in_alucontrol` in 3, ALU opcode, passed through.
- `in_regwrite` in 1, instruction writes `rd`.
- `flush` in 1, kill all held and incoming instructions.
- `mem_regwrite` in 1, `mem_rd` in 5, `mem_result` in XLEN: EX/MEM bypass.
- `wb_regwrite` in 1, `wb_rd` in 5, `wb_result` in XLEN: writeback bus.
- `out_valid` out 1, head entry valid.
- `out_ready` in 1, execute consumes the head.
- `a`, `b` out XLEN, final ALU operands.
- `store_data` out XLEN, bypassed rs2 value.
- `alucontrol` out 3, `rd` out 5, `regwrite` out 1: head control fields.

## Operation
- **Entry contents:** each entry holds rs1 and rs2 values and addresses, imm, alusrc, alucontrol, rd, regwrite, and a valid bit.
- **Accept:** an instruction is accepted on a rising edge with `in_valid && in_ready && !flush`.
- **Head and skid:** the head is the entry presented on the outputs; the skid entry holds overflow (see Configuration).
- **Consume:** on `out_valid && out_ready` the head retires and the skid entry, if valid, moves to the head.
- **WB snoop:** every cycle, each held entry whose `rs1` or `rs2` equals `wb_rd`, with `wb_regwrite` set and `wb_rd != 0`, captures `wb_result` into that operand. A stalled instruction therefore never loses a writeback.
- **Incoming operands at capture:** WB forwarding is applied to incoming operands on the accepting edge.
- **Output bypass:** combinational, priority MEM > stored value. The rs1 value is `mem_result` if `mem_regwrite`, `mem_rd != 0` and `mem_rd == head.rs1`; the same rule applies to rs2.
- **ALU operands:** `a` is the bypassed rs1. `b` is `imm` when alusrc is set, else the bypassed rs2. `store_data` is always the bypassed rs2.
- **Register x0:** address 0 never matches any bypass or snoop.
- **Flush:** synchronous. It clears every valid bit and drops the same-cycle input; flush overrides accept and consume.
- **Empty outputs:** when `out_valid` = 0, `regwrite` is forced to 0 and the data outputs hold their last values.

## Timing
- **Latency:** 1 cycle from accept to `out_valid`. Throughput is 1 per cycle while `out_ready` = 1.
- **Reset:** asynchronous. All valid bits, registered fields, `regwrite` and `alucontrol` go to 0; `a`, `b` and `store_data` go to 0; `out_valid` = 0; `in_ready` = 1 after reset deasserts.
- **Reset mid-operation:** drops held instructions immediately, with no partial outputs.
- **Output stability:** while `out_valid && !out_ready`, the control outputs are stable. `a` and `b` may change only through MEM bypass or WB snoop.
- **Simultaneous consume + accept + snoop:** the snoop applies to the entry that lands in each slot.
- **Full (skid mode):** both entries valid gives `in_ready` = 0. `in_ready` returns to 1 the cycle after a consume.

## Configuration
- `ID_EX_SKID_EN` defined: two-entry skid buffer. `in_ready` is registered and equal to `!skid.valid`, which removes the combinational ready path from execute to decode.
- `ID_EX_SKID_EN` undefined: single head entry. `in_ready = !out_valid || out_ready` (combinational), and the skid logic is absent.
- Both builds have identical cycle behaviour whenever `out_ready` is held at 1.

## Structure
- **Shared package `rv_pipe_pkg`:** `XLEN` and the ALU opcode constants: `ALU_ADD`=000, `ALU_SUB`=001, `ALU_AND`=010, `ALU_OR`=011, `ALU_XOR`=100, `ALU_SLT`=101, `ALU_SLL`=110, `ALU_SRL`=111. It also holds the id_ex entry record type.
- **Sub-module `operand_bypass`:** instantiated twice (rs1, rs2). It does the combinational address compare with the x0 guard, selects MEM over the stored value, and produces the WB snoop-hit flag.

## Test plan
- **Basic pass-through:** accept addi with rs1=5, value 10, imm=7, alusrc=1 -> next cycle `out_valid`=1, `a`=10, `b`=7, `alucontrol`=000.
- **MEM bypass:** head rs1=3 (stored 1), `mem_regwrite`=1, `mem_rd`=3, `mem_result`=0x55 -> `a`=0x55. With `mem_rd`=0 instead -> `a`=1.
- **Stall with WB snoop:** head rs2=4 stored 0, `out_ready`=0, `wb_rd`=4, `wb_result`=9 -> the following cycles show `b`=9 and `store_data`=9 after WB deasserts.
- **Skid backpressure (`ID_EX_SKID_EN`):** 3 back-to-back accepts with `out_ready`=0 -> 2 accepted, `in_ready`=0, then release yields in-order output over 2 cycles.
- **Flush:** flush asserted with 2 held entries and `in_valid`=1 -> next cycle `out_valid`=0, and nothing emerges afterwards.
- **Async reset:** `reset_n` low mid-stream, off-edge -> `out_valid`=0 and `regwrite`=0 immediately, then `in_ready`=1 after release.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pipe_pkg
// Description : Shared RV32 pipeline types, ALU opcodes and bypass helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic            alusrc;
        logic [2:0]      alucontrol;
        logic [4:0]      rd;
        logic            regwrite;
    } id_ex_entry_t;

    // x0 is hardwired zero, so it can never be the target of a forward.
    function automatic logic reg_hit(input logic       we,
                                     input logic [4:0] wr_rd,
                                     input logic [4:0] rs);
        return we && (wr_rd != 5'd0) && (wr_rd == rs);
    endfunction

    function automatic id_ex_entry_t wb_snoop(input id_ex_entry_t    e,
                                              input logic            we,
                                              input logic [4:0]      wr_rd,
                                              input logic [XLEN-1:0] res);
        id_ex_entry_t r;
        r = e;
        if (reg_hit(we, wr_rd, e.rs1)) r.rs1_val = res;
        if (reg_hit(we, wr_rd, e.rs2)) r.rs2_val = res;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : Decode/bypass/execute bundle around the ID/EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if;
    import rv_pipe_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [4:0]      in_rd;
    logic            in_alusrc;
    logic [2:0]      in_alucontrol;
    logic            in_regwrite;
    logic            flush;
    logic            mem_regwrite;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_result;
    logic            wb_regwrite;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_result;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] store_data;
    logic [2:0]      alucontrol;
    logic [4:0]      rd;
    logic            regwrite;

    modport master (
        output in_valid, in_rs1_data, in_rs2_data, in_imm, in_rs1, in_rs2, in_rd,
               in_alusrc, in_alucontrol, in_regwrite, flush,
               mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_result,
               out_ready,
        input  in_ready, out_valid, a, b, store_data, alucontrol, rd, regwrite
    );

    modport slave (
        input  in_valid, in_rs1_data, in_rs2_data, in_imm, in_rs1, in_rs2, in_rd,
               in_alusrc, in_alucontrol, in_regwrite, flush,
               mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_result,
               out_ready,
        output in_ready, out_valid, a, b, store_data, alucontrol, rd, regwrite
    );

endinterface
`default_nettype wire

// File: rtl/operand_bypass.sv
`default_nettype none
// ============================================================================
// Module      : operand_bypass
// Description : One source operand: MEM-over-stored select plus WB snoop hit.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_bypass
    import rv_pipe_pkg::*;
(
    input  logic [4:0]      rs_i,
    input  logic [XLEN-1:0] stored_i,
    input  logic            mem_regwrite_i,
    input  logic [4:0]      mem_rd_i,
    input  logic [XLEN-1:0] mem_result_i,
    input  logic            wb_regwrite_i,
    input  logic [4:0]      wb_rd_i,
    output logic [XLEN-1:0] value_o,
    output logic            wb_hit_o
);

    always_comb begin
        value_o  = reg_hit(mem_regwrite_i, mem_rd_i, rs_i) ? mem_result_i : stored_i;
        wb_hit_o = reg_hit(wb_regwrite_i, wb_rd_i, rs_i);
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with MEM/WB bypass, stall and flush.
//               Define ID_EX_SKID_EN for a two-entry skid with registered ready.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import rv_pipe_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    id_ex_stage_if.slave  bus
);

    id_ex_entry_t    head_q;
    id_ex_entry_t    head_d;
    id_ex_entry_t    w_head_snp;
    id_ex_entry_t    w_in_entry;

    logic [XLEN-1:0] w_rs1_byp;
    logic [XLEN-1:0] w_rs2_byp;
    logic            w_rs1_wb_hit;
    logic            w_rs2_wb_hit;
    logic [XLEN-1:0] w_a;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_consume;

    logic [XLEN-1:0] a_hold_q;
    logic [XLEN-1:0] b_hold_q;
    logic [XLEN-1:0] sd_hold_q;

    operand_bypass u_byp_rs1 (
        .rs_i           (head_q.rs1),
        .stored_i       (head_q.rs1_val),
        .mem_regwrite_i (bus.mem_regwrite),
        .mem_rd_i       (bus.mem_rd),
        .mem_result_i   (bus.mem_result),
        .wb_regwrite_i  (bus.wb_regwrite),
        .wb_rd_i        (bus.wb_rd),
        .value_o        (w_rs1_byp),
        .wb_hit_o       (w_rs1_wb_hit)
    );

    operand_bypass u_byp_rs2 (
        .rs_i           (head_q.rs2),
        .stored_i       (head_q.rs2_val),
        .mem_regwrite_i (bus.mem_regwrite),
        .mem_rd_i       (bus.mem_rd),
        .mem_result_i   (bus.mem_result),
        .wb_regwrite_i  (bus.wb_regwrite),
        .wb_rd_i        (bus.wb_rd),
        .value_o        (w_rs2_byp),
        .wb_hit_o       (w_rs2_wb_hit)
    );

    assign w_a       = w_rs1_byp;
    assign w_accept  = bus.in_valid && w_in_ready && !bus.flush;
    assign w_consume = head_q.valid && bus.out_ready;

    // Incoming operands pick up a same-cycle writeback before landing.
    always_comb begin
        w_in_entry            = '0;
        w_in_entry.valid      = 1'b1;
        w_in_entry.rs1        = bus.in_rs1;
        w_in_entry.rs2        = bus.in_rs2;
        w_in_entry.rs1_val    = bus.in_rs1_data;
        w_in_entry.rs2_val    = bus.in_rs2_data;
        w_in_entry.imm        = bus.in_imm;
        w_in_entry.alusrc     = bus.in_alusrc;
        w_in_entry.alucontrol = bus.in_alucontrol;
        w_in_entry.rd         = bus.in_rd;
        w_in_entry.regwrite   = bus.in_regwrite;
        w_in_entry            = wb_snoop(w_in_entry, bus.wb_regwrite, bus.wb_rd, bus.wb_result);
    end

    always_comb begin
        w_head_snp = head_q;
        if (w_rs1_wb_hit) w_head_snp.rs1_val = bus.wb_result;
        if (w_rs2_wb_hit) w_head_snp.rs2_val = bus.wb_result;
    end

`ifdef ID_EX_SKID_EN
    id_ex_entry_t skid_q;
    id_ex_entry_t skid_d;
    id_ex_entry_t w_skid_snp;
    logic         in_ready_q;

    assign w_in_ready = in_ready_q;
    assign w_skid_snp = wb_snoop(skid_q, bus.wb_regwrite, bus.wb_rd, bus.wb_result);

    // Skid only fills while the head is stalled, and ready is low while
    // it is full, so accept and skid-promote never coincide.
    always_comb begin
        head_d = w_head_snp;
        skid_d = w_skid_snp;
        if (bus.flush) begin
            head_d.valid = 1'b0;
            skid_d.valid = 1'b0;
        end else if (!head_q.valid || w_consume) begin
            if (skid_q.valid) begin
                head_d       = w_skid_snp;
                skid_d.valid = 1'b0;
            end else if (w_accept) begin
                head_d = w_in_entry;
            end else begin
                head_d.valid = 1'b0;
            end
        end else if (w_accept) begin
            skid_d = w_in_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            skid_q     <= skid_d;
            in_ready_q <= !skid_d.valid;
        end
    end
`else
    assign w_in_ready = !head_q.valid || bus.out_ready;

    always_comb begin
        head_d = w_head_snp;
        if (bus.flush) begin
            head_d.valid = 1'b0;
        end else if (w_accept) begin
            head_d = w_in_entry;
        end else if (w_consume) begin
            head_d.valid = 1'b0;
        end
    end
`endif

    // Hold registers keep the operand outputs frozen while the stage is empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q    <= '0;
            a_hold_q  <= '0;
            b_hold_q  <= '0;
            sd_hold_q <= '0;
        end else begin
            head_q <= head_d;
            if (head_q.valid) begin
                a_hold_q  <= bus.a;
                b_hold_q  <= bus.b;
                sd_hold_q <= bus.store_data;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = head_q.valid;
    assign bus.a          = head_q.valid ? w_a : a_hold_q;
    assign bus.b          = head_q.valid ? (head_q.alusrc ? head_q.imm : w_rs2_byp) : b_hold_q;
    assign bus.store_data = head_q.valid ? w_rs2_byp : sd_hold_q;
    assign bus.alucontrol = head_q.alucontrol;
    assign bus.rd         = head_q.rd;
    assign bus.regwrite   = head_q.valid && head_q.regwrite;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Randomized self-checking bench against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    typedef struct {
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic        alusrc;
        logic        we;
        logic [2:0]  op;
    } ins_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    ins_t        q[$];
    logic [31:0] last_a, last_b, last_sd;
    logic [2:0]  last_op;
    logic [4:0]  last_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_fwd(input logic [4:0] r, input logic [31:0] v);
        if (bus.mem_regwrite && bus.mem_rd != 5'd0 && bus.mem_rd == r) return bus.mem_result;
        return v;
    endfunction

    function automatic logic [31:0] wb_fwd(input logic [4:0] r, input logic [31:0] v);
        if (bus.wb_regwrite && bus.wb_rd != 5'd0 && bus.wb_rd == r) return bus.wb_result;
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        last_a  = '0;
        last_b  = '0;
        last_sd = '0;
        last_op = '0;
        last_rd = '0;
    endtask

    task automatic drive_idle();
        bus.in_valid      = 1'b0;
        bus.in_rs1_data   = '0;
        bus.in_rs2_data   = '0;
        bus.in_imm        = '0;
        bus.in_rs1        = '0;
        bus.in_rs2        = '0;
        bus.in_rd         = '0;
        bus.in_alusrc     = 1'b0;
        bus.in_alucontrol = '0;
        bus.in_regwrite   = 1'b0;
        bus.flush         = 1'b0;
        bus.mem_regwrite  = 1'b0;
        bus.mem_rd        = '0;
        bus.mem_result    = '0;
        bus.wb_regwrite   = 1'b0;
        bus.wb_rd         = '0;
        bus.wb_result     = '0;
        bus.out_ready     = 1'b0;
    endtask

    task automatic drive_random();
        bus.in_valid      = ($urandom % 4) != 0;
        bus.in_rs1_data   = $urandom;
        bus.in_rs2_data   = $urandom;
        bus.in_imm        = $urandom;
        bus.in_rs1        = 5'($urandom % 4);
        bus.in_rs2        = 5'($urandom % 4);
        bus.in_rd         = 5'($urandom % 32);
        bus.in_alusrc     = 1'($urandom % 2);
        bus.in_alucontrol = 3'($urandom % 8);
        bus.in_regwrite   = 1'($urandom % 2);
        bus.flush         = ($urandom % 20) == 0;
        bus.mem_regwrite  = 1'($urandom % 2);
        bus.mem_rd        = 5'($urandom % 4);
        bus.mem_result    = $urandom;
        bus.wb_regwrite   = 1'($urandom % 2);
        bus.wb_rd         = 5'($urandom % 4);
        bus.wb_result     = $urandom;
        bus.out_ready     = ($urandom % 3) != 0;
    endtask

    // Compare outputs for the current inputs, then advance the model one edge.
    task automatic check_and_step();
        logic        exp_rdy;
        logic        exp_we;
        logic [31:0] ea, eb, esd;
        logic        acc, cons;
        ins_t        n;
`ifdef ID_EX_SKID_EN
        exp_rdy = q.size() < 2;
`else
        exp_rdy = (q.size() == 0) || bus.out_ready;
`endif
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        exp_we = 1'b0;
        if (q.size() != 0) begin
            ea      = mem_fwd(q[0].r1, q[0].v1);
            esd     = mem_fwd(q[0].r2, q[0].v2);
            eb      = q[0].alusrc ? q[0].imm : esd;
            last_a  = ea;
            last_b  = eb;
            last_sd = esd;
            last_op = q[0].op;
            last_rd = q[0].rd;
            exp_we  = q[0].we;
        end
        chk("a", bus.a, last_a);
        chk("b", bus.b, last_b);
        chk("store_data", bus.store_data, last_sd);
        chk("alucontrol", 32'(bus.alucontrol), 32'(last_op));
        chk("rd", 32'(bus.rd), 32'(last_rd));
        chk("regwrite", 32'(bus.regwrite), 32'(exp_we));

        acc  = bus.in_valid && exp_rdy && !bus.flush;
        cons = (q.size() != 0) && bus.out_ready;
        foreach (q[i]) begin
            q[i].v1 = wb_fwd(q[i].r1, q[i].v1);
            q[i].v2 = wb_fwd(q[i].r2, q[i].v2);
        end
        if (bus.flush) begin
            q.delete();
        end else begin
            if (cons) void'(q.pop_front());
            if (acc) begin
                n.r1     = bus.in_rs1;
                n.r2     = bus.in_rs2;
                n.rd     = bus.in_rd;
                n.v1     = wb_fwd(bus.in_rs1, bus.in_rs1_data);
                n.v2     = wb_fwd(bus.in_rs2, bus.in_rs2_data);
                n.imm    = bus.in_imm;
                n.alusrc = bus.in_alusrc;
                n.we     = bus.in_regwrite;
                n.op     = bus.in_alucontrol;
                q.push_back(n);
            end
        end
    endtask

    initial begin
        drive_idle();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst regwrite", 32'(bus.regwrite), 32'd0);
        chk("rst a", bus.a, 32'd0);
        chk("rst b", bus.b, 32'd0);
        chk("rst store_data", bus.store_data, 32'd0);
        chk("rst alucontrol", 32'(bus.alucontrol), 32'd0);
        reset_n = 1'b1;

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            drive_random();
            #1;
            check_and_step();
        end

        // Ensure something is held, then pull reset between clock edges.
        @(negedge clk);
        drive_random();
        bus.in_valid    = 1'b1;
        bus.in_regwrite = 1'b1;
        bus.flush       = 1'b0;
        bus.out_ready   = 1'b0;
        #1;
        check_and_step();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async out_valid", 32'(bus.out_valid), 32'd0);
        chk("async regwrite", 32'(bus.regwrite), 32'd0);
        model_reset();
        @(negedge clk);
        drive_idle();
        reset_n = 1'b1;
        #1;
        check_and_step();

        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            drive_random();
            #1;
            check_and_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
